// File: rtl/rca_4b_pkg.sv
// rtl/rca_4b_pkg.sv - shared constants for the registered ripple-carry adder
// Purpose: holds the default operand width used by rca_4b.
// Ports: none (package).
package rca_4b_pkg;
   localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/rca_4b_full_adder.sv
// rtl/rca_4b_full_adder.sv - single-bit full adder cell for the ripple chain
// Purpose: one bit of the ripple-carry adder.
// Ports:
//   a, b  in   operand bits
//   cin   in   carry into this bit
//   s     out  sum bit
//   cout  out  carry out of this bit
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);
   logic p;

   assign p    = a ^ b;
   assign s    = p ^ cin;
   assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/rca_4b.sv
// rtl/rca_4b.sv - registered WIDTH-bit ripple-carry adder with overflow and valid
// Purpose: {c_out,sum} = a + b + c_in through a ripple of full_adder cells,
//          captured one clock after in_valid is sampled.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   a/b/c_in valid this cycle
//   a, b       in   WIDTH-bit operands
//   c_in       in   carry into bit 0
//   sum        out  registered low WIDTH bits of the result
//   c_out      out  registered carry out of the MSB
//   ovf        out  registered signed overflow
//   out_valid  out  registered in_valid, qualifies sum/c_out/ovf
module rca_4b
   import rca_4b_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             out_valid
);
   logic [WIDTH:0]   c;
   logic [WIDTH-1:0] s;
   logic             ovf_comb;

   assign c[0] = c_in;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      full_adder u_fa (
         .a   (a[i]),
         .b   (b[i]),
         .cin (c[i]),
         .s   (s[i]),
         .cout(c[i+1])
      );
   end

   // Signed overflow: carry into the sign bit disagrees with carry out of it.
   assign ovf_comb = c[WIDTH-1] ^ c[WIDTH];

   // Results hold while idle so the last valid add stays observable.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum       <= '0;
         c_out     <= 1'b0;
         ovf       <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            sum   <= s;
            c_out <= c[WIDTH];
            ovf   <= ovf_comb;
         end
      end
   end
endmodule

// File: tb/tb_rca_4b.sv
// tb/tb_rca_4b.sv - self-checking bench for rca_4b
module tb_rca_4b;
   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [3:0] a;
   logic [3:0] b;
   logic       c_in;
   logic [3:0] sum;
   logic       c_out;
   logic       ovf;
   logic       out_valid;

   int tests_run    = 0;
   int tests_failed = 0;

   rca_4b #(.WIDTH(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .sum      (sum),
      .c_out    (c_out),
      .ovf      (ovf),
      .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   // Reference: plain integer arithmetic, signed overflow from range check.
   // Returns {ovf, c_out, sum[3:0]}.
   function automatic logic [5:0] ref_add(input int ai, input int bi, input int ci);
      int tot;
      int sa;
      int sb;
      int st;
      logic ov;
      tot = ai + bi + ci;
      sa  = (ai >= 8) ? ai - 16 : ai;
      sb  = (bi >= 8) ? bi - 16 : bi;
      st  = sa + sb + ci;
      ov  = (st > 7) || (st < -8);
      return {ov, tot[4], tot[3:0]};
   endfunction

   task automatic drive(input logic r, input logic v, input int ai, input int bi, input int ci);
      rst      = r;
      in_valid = v;
      a        = ai[3:0];
      b        = bi[3:0];
      c_in     = ci[0];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive(1'b1, 1'b1, 15, 15, 1);
      for (int i = 0; i < 2; i++) begin
         step();
         tests_run++;
         if ({out_valid, ovf, c_out, sum} !== 7'b0) begin
            tests_failed++;
            $display("FAIL reset_during cyc%0d: got v=%b o=%b c=%b s=%b, want all 0",
                     i, out_valid, ovf, c_out, sum);
         end
      end
      drive(1'b0, 1'b0, 15, 15, 1);
      step();
      tests_run++;
      if ({out_valid, ovf, c_out, sum} !== 7'b0) begin
         tests_failed++;
         $display("FAIL reset_after: got v=%b o=%b c=%b s=%b, want all 0",
                  out_valid, ovf, c_out, sum);
      end
   endtask

   task automatic test_basic();
      int va [3] = '{0, 10, 15};
      int vb [3] = '{0, 5, 15};
      int vc [3] = '{0, 0, 1};
      logic [5:0] want [3] = '{6'b00_0000, 6'b00_1111, 6'b01_1111};
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b1, va[i], vb[i], vc[i]);
         step();
         tests_run++;
         if (out_valid !== 1'b1 || {ovf, c_out, sum} !== want[i]) begin
            tests_failed++;
            $display("FAIL basic_%0d: got v=%b {ovf,c,s}=%b, want v=1 %b",
                     i, out_valid, {ovf, c_out, sum}, want[i]);
         end
      end
      drive(1'b0, 1'b0, 0, 0, 0);
      step();
   endtask

   task automatic test_ripple_ovf();
      int va [4] = '{0, 15, 7, 8};
      int vb [4] = '{0, 0, 1, 8};
      int vc [4] = '{1, 1, 0, 0};
      logic [5:0] want [4] = '{6'b00_0001, 6'b01_0000, 6'b10_1000, 6'b11_0000};
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, va[i], vb[i], vc[i]);
         step();
         tests_run++;
         if (out_valid !== 1'b1 || {ovf, c_out, sum} !== want[i]) begin
            tests_failed++;
            $display("FAIL ripple_ovf_%0d: got v=%b {ovf,c,s}=%b, want v=1 %b",
                     i, out_valid, {ovf, c_out, sum}, want[i]);
         end
      end
   endtask

   task automatic test_hold();
      drive(1'b0, 1'b1, 3, 4, 0);
      step();
      tests_run++;
      if (out_valid !== 1'b1 || {ovf, c_out, sum} !== 6'b00_0111) begin
         tests_failed++;
         $display("FAIL hold_load: got v=%b {ovf,c,s}=%b, want v=1 000111",
                  out_valid, {ovf, c_out, sum});
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, int'($urandom_range(15)), int'($urandom_range(15)),
               int'($urandom_range(1)));
         step();
         tests_run++;
         if (out_valid !== 1'b0 || {ovf, c_out, sum} !== 6'b00_0111) begin
            tests_failed++;
            $display("FAIL hold_%0d: got v=%b {ovf,c,s}=%b, want v=0 000111",
                     i, out_valid, {ovf, c_out, sum});
         end
      end
   endtask

   task automatic test_exhaustive();
      logic [5:0] want;
      int errs = 0;
      for (int ci = 0; ci < 2; ci++) begin
         for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
               drive(1'b0, 1'b1, ai, bi, ci);
               want = ref_add(ai, bi, ci);
               step();
               tests_run++;
               if (out_valid !== 1'b1 || {ovf, c_out, sum} !== want) begin
                  tests_failed++;
                  errs++;
                  if (errs <= 10)
                     $display("FAIL exhaustive a=%0d b=%0d ci=%0d: got v=%b %b, want v=1 %b",
                              ai, bi, ci, out_valid, {ovf, c_out, sum}, want);
               end
            end
         end
      end
   endtask

   // Random mix of valid and idle cycles; the model tracks held results.
   task automatic test_random();
      logic [5:0] held;
      logic       vld;
      int ai, bi, ci;
      held = {ovf, c_out, sum};
      for (int i = 0; i < 300; i++) begin
         vld = ($urandom_range(3) != 0);
         ai  = int'($urandom_range(15));
         bi  = int'($urandom_range(15));
         ci  = int'($urandom_range(1));
         drive(1'b0, vld, ai, bi, ci);
         if (vld) held = ref_add(ai, bi, ci);
         step();
         tests_run++;
         if (out_valid !== vld || {ovf, c_out, sum} !== held) begin
            tests_failed++;
            $display("FAIL random_%0d: got v=%b %b, want v=%b %b",
                     i, out_valid, {ovf, c_out, sum}, vld, held);
         end
      end
   endtask

   task automatic test_reset_midstream();
      drive(1'b0, 1'b1, 9, 9, 1);
      step();
      drive(1'b1, 1'b1, 5, 5, 0);
      step();
      tests_run++;
      if ({out_valid, ovf, c_out, sum} !== 7'b0) begin
         tests_failed++;
         $display("FAIL reset_mid: got v=%b o=%b c=%b s=%b, want all 0",
                  out_valid, ovf, c_out, sum);
      end
      drive(1'b0, 1'b1, 5, 5, 0);
      step();
      tests_run++;
      if (out_valid !== 1'b1 || {ovf, c_out, sum} !== 6'b10_1010) begin
         tests_failed++;
         $display("FAIL reset_mid_reapply: got v=%b {ovf,c,s}=%b, want v=1 101010",
                  out_valid, {ovf, c_out, sum});
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, 0, 0, 0);
      #1;
      test_reset();
      test_basic();
      test_ripple_ovf();
      test_hold();
      test_exhaustive();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
